// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART baud-rate generator.
// Holds the rate-code width, the rate-code enumeration, the baud-rate lookup
// and the rate-code validity check used by the generator and its interface.
package uart_pkg;

    localparam int unsigned SEL_W    = 3;
    localparam int unsigned BAUD_MAX = 115_200;

    typedef enum logic [SEL_W-1:0] {
        BAUD_9600   = 3'd0,
        BAUD_19200  = 3'd1,
        BAUD_38400  = 3'd2,
        BAUD_57600  = 3'd3,
        BAUD_115200 = 3'd4
    } baud_code_e;

    function automatic logic sel_valid(input logic [SEL_W-1:0] code);
        return (code <= BAUD_115200);
    endfunction

    // Invalid codes map to 9600 so the increment is always well defined.
    function automatic int unsigned baud_rate(input logic [SEL_W-1:0] code);
        case (code)
            BAUD_19200:  return 19_200;
            BAUD_38400:  return 38_400;
            BAUD_57600:  return 57_600;
            BAUD_115200: return 115_200;
            default:     return 9_600;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// uart_baud_gen_if: control/status bundle of the baud-rate generator.
//   en, restart, baud_sel        : driven by the controller (master)
//   rx_tick, tx_tick,
//   active_sel, sel_err          : driven by the generator (slave)
interface uart_baud_gen_if;
    import uart_pkg::*;

    logic             en;
    logic             restart;
    logic [SEL_W-1:0] baud_sel;
    logic             rx_tick;
    logic             tx_tick;
    logic [SEL_W-1:0] active_sel;
    logic             sel_err;

    modport master (
        output en, restart, baud_sel,
        input  rx_tick, tx_tick, active_sel, sel_err
    );

    modport slave (
        input  en, restart, baud_sel,
        output rx_tick, tx_tick, active_sel, sel_err
    );

endinterface

// File: rtl/uart_phase_acc.sv
// uart_phase_acc: fractional phase accumulator producing rx_tick.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : restart; zeroes the phase
//   step       : advance the phase by inc this cycle
//   inc        : phase increment (OVERSAMPLE x baud)
//   tick_next  : combinational, rx_tick will be set at the coming edge
//   rx_tick    : registered one-cycle tick
module uart_phase_acc #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned ACC_W    = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    input  logic [ACC_W-1:0] inc,
    output logic             tick_next,
    output logic             rx_tick
);

    localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLK_FREQ);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic             wrap;

    // acc < CLK_FREQ and inc < CLK_FREQ, so sum < 2*CLK_FREQ fits in ACC_W.
    always_comb begin
        sum       = acc + inc;
        wrap      = (sum >= LIMIT);
        tick_next = step && !clear && wrap;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc     <= '0;
            rx_tick <= 1'b0;
        end else if (step) begin
            acc     <= wrap ? (sum - LIMIT) : sum;
            rx_tick <= wrap;
        end else begin
            rx_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: UART baud-rate generator with exact long-term rate.
//   clk, rst : clock, synchronous active-high reset
//   bus      : uart_baud_gen_if.slave
//     en         run enable (0 holds phase)
//     restart    resynchronise phase and load baud_sel
//     baud_sel   rate code 0..4 (9600..115200), 5..7 invalid
//     rx_tick    pulse at OVERSAMPLE x baud
//     tx_tick    pulse at baud, on every OVERSAMPLE-th rx_tick
//     active_sel rate code in use
//     sel_err    pulse after a restart with an invalid code
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned ACC_W      = 28
) (
    input logic            clk,
    input logic            rst,
    uart_baud_gen_if.slave bus
);

    localparam int unsigned OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    if (OVERSAMPLE < 2 || OVERSAMPLE > 64) begin : g_bad_oversample
        $error("uart_baud_gen: OVERSAMPLE must be in 2..64");
    end
    if (64'(OVERSAMPLE) * 64'(BAUD_MAX) >= 64'(CLK_FREQ)) begin : g_bad_rate
        $error("uart_baud_gen: OVERSAMPLE x 115200 must be below CLK_FREQ");
    end
    if (ACC_W < 64 && (64'd1 << ACC_W) <= 64'd2 * 64'(CLK_FREQ)) begin : g_bad_acc_w
        $error("uart_baud_gen: ACC_W too narrow for 2*CLK_FREQ");
    end

    baud_code_e       active;
    logic [OS_W-1:0]  os_cnt;
    logic             tx_tick;
    logic             sel_err;
    logic [ACC_W-1:0] inc;
    logic             tick_next;
    logic             rx_tick;

    always_comb begin
        inc = ACC_W'(OVERSAMPLE * baud_rate(active));
    end

    uart_phase_acc #(
        .CLK_FREQ (CLK_FREQ),
        .ACC_W    (ACC_W)
    ) u_phase (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.restart),
        .step      (bus.en),
        .inc       (inc),
        .tick_next (tick_next),
        .rx_tick   (rx_tick)
    );

    // tick_next is the same-edge view of rx_tick, so tx_tick lands with the
    // rx_tick that completes the bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            os_cnt  <= '0;
            tx_tick <= 1'b0;
            sel_err <= 1'b0;
            active  <= BAUD_9600;
        end else if (bus.restart) begin
            os_cnt  <= '0;
            tx_tick <= 1'b0;
            sel_err <= !sel_valid(bus.baud_sel);
            active  <= sel_valid(bus.baud_sel) ? baud_code_e'(bus.baud_sel) : BAUD_9600;
        end else begin
            sel_err <= 1'b0;
            tx_tick <= 1'b0;
            if (tick_next) begin
                if (os_cnt == OS_LAST) begin
                    os_cnt  <= '0;
                    tx_tick <= 1'b1;
                end else begin
                    os_cnt <= os_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.rx_tick    = rx_tick;
        bus.tx_tick    = tx_tick;
        bus.active_sel = active;
        bus.sel_err    = sel_err;
    end

endmodule

// File: doc/uart_baud_gen.md
UART_BAUD_GEN -- requirements
Module: uart_baud_gen

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter OVERSAMPLE, default 16, rx_tick pulses per bit period; legal range 2..64.
REQ-003 Parameter ACC_W, default 28, phase accumulator width; must satisfy 2^ACC_W > 2*CLK_FREQ.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 en  input  1  run enable; 0 holds the generator idle.
REQ-007 restart  input  1  single-cycle pulse; resynchronises phase and loads baud_sel.
REQ-008 baud_sel  input  3  rate code: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200; 5..7 invalid.
REQ-009 rx_tick  output  1  registered one-cycle pulse at OVERSAMPLE x baud rate.
REQ-010 tx_tick  output  1  registered one-cycle pulse at baud rate, coincident with every OVERSAMPLE-th rx_tick.
REQ-011 active_sel  output  3  rate code currently in use.
REQ-012 sel_err  output  1  one-cycle pulse when restart loaded an invalid code.

Function
REQ-013 Increment INC = OVERSAMPLE x baud(active_sel); the block SHALL reject at elaboration any configuration where OVERSAMPLE x 115200 >= CLK_FREQ.
REQ-014 Each cycle with en=1 and restart=0: sum = acc + INC; if sum >= CLK_FREQ then acc <= sum - CLK_FREQ and rx_tick <= 1, else acc <= sum and rx_tick <= 0.
REQ-015 Oversample counter os_cnt (0..OVERSAMPLE-1) SHALL advance only on cycles that assert rx_tick; when os_cnt == OVERSAMPLE-1 it wraps to 0 and tx_tick <= 1 in the same cycle as rx_tick.
REQ-016 Long-term tick rate SHALL be exact: over CLK_FREQ enabled cycles, exactly OVERSAMPLE x baud rx_ticks and baud tx_ticks; no cumulative drift.
REQ-017 restart=1 (priority over en): acc <= 0, os_cnt <= 0, rx_tick <= 0, tx_tick <= 0, active_sel <= baud_sel if valid, else 0 and sel_err <= 1.
REQ-018 baud_sel SHALL be ignored except on restart cycles; a rate change never takes effect mid-bit.
REQ-019 en=0 and restart=0: acc and os_cnt hold their values; rx_tick, tx_tick = 0; en returning to 1 resumes phase without loss.
REQ-020 sel_err SHALL be 0 in every cycle not immediately following an invalid-code restart.
REQ-021 Latency: first rx_tick after restart appears on the N-th enabled cycle, N = ceil(CLK_FREQ / INC).

Reset
REQ-022 rst=1 (priority over restart and en): acc=0, os_cnt=0, rx_tick=0, tx_tick=0, sel_err=0, active_sel=0 (9600).
REQ-023 Reset asserted mid-bit SHALL abort the bit period; no tick in the cycle after reset release unless REQ-021 timing is reached.

Structure
REQ-024 Shared package uart_pkg SHALL hold the baud-rate table, rate-code width (3), code localparams and the valid-code check function.
REQ-025 One sub-module, uart_phase_acc (accumulator plus compare/subtract, emitting rx_tick), SHALL be instantiated; os_cnt, select latch and sel_err remain in uart_baud_gen.

Verification
REQ-026 Defaults, restart with baud_sel=0, en=1 -> first rx_tick on enabled cycle 652, first tx_tick at the 16th rx_tick.
REQ-027 Defaults, baud_sel=0, run 100_000_000 cycles -> exactly 153_600 rx_ticks and 9_600 tx_ticks; rx_tick spacing only 651 or 652.
REQ-028 restart with baud_sel=4 -> first rx_tick at cycle 55, spacing only 54 or 55, active_sel=4; change baud_sel to 1 without restart -> spacing unchanged.
REQ-029 restart with baud_sel=6 -> sel_err high one cycle, active_sel=0, 9600 timing per REQ-026.
REQ-030 Drop en for 1000 cycles mid-bit -> no ticks while low; next rx_tick lands exactly 1000 cycles later than undisturbed run.
REQ-031 rst and restart asserted together mid-bit -> all outputs 0, active_sel=0, baud_sel ignored.
